// File: rtl/fs_serial_if.sv
// rtl/fs_serial_if.sv - request/result bundle for the bit-serial subtractor
interface fs_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;

  modport master (output start, a, b, bi, input busy, done, d, bo);
  modport slave  (input start, a, b, bi, output busy, done, d, bo);
endinterface

// File: rtl/fs_serial.sv
// rtl/fs_serial.sv - bit-serial full subtractor, LSB first, start/busy/done handshake
module fs_serial #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fs_serial_if.slave  io
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;

  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // Operands shift right so bit 0 is always the bit under work.
  assign diff_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next   = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
  assign res_shift = (res_q >> 1) | {diff_bit, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          a_d     = io.a;
          b_d     = io.b;
          br_d    = io.bi;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = res_shift;
          bo_d    = br_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end

  assign io.busy = (state_q == RUN);
  assign io.done = (state_q == DONE);
  assign io.d    = d_q;
  assign io.bo   = bo_q;
endmodule

// File: tb/tb_fs_serial.sv
// tb/tb_fs_serial.sv - scoreboard bench for fs_serial at WIDTH=4 and WIDTH=8
module tb_fs_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fs_serial_if #(.WIDTH(4)) if4 ();
  fs_serial_if #(.WIDTH(8)) if8 ();

  fs_serial #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
  fs_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Expected word: {bo, d}
  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] last4 = '0;
  logic [8:0] last8 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] m4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {4'b0, bi};
  endfunction

  function automatic logic [8:0] m8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'b0, bi};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q8.delete();
      last4 = '0;
      last8 = '0;
    end else begin
      if (if4.done) begin
        if (q4.size() == 0) chk("unexpected_done4", 32'(q4.size()), 32'd1);
        else begin
          last4 = q4.pop_front();
          chk("result4", 32'({if4.bo, if4.d}), 32'(last4));
        end
      end else chk("hold4", 32'({if4.bo, if4.d}), 32'(last4));
      if (if8.done) begin
        if (q8.size() == 0) chk("unexpected_done8", 32'(q8.size()), 32'd1);
        else begin
          last8 = q8.pop_front();
          chk("result8", 32'({if8.bo, if8.d}), 32'(last8));
        end
      end else chk("hold8", 32'({if8.bo, if8.d}), 32'(last8));
    end
  end

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                      input logic [4:0] exp, input bit hold);
    int n;
    int nb;
    if4.a = a; if4.b = b; if4.bi = bi; if4.start = 1'b1;
    q4.push_back(exp);
    @(posedge clk); #1;
    if (!hold) if4.start = 1'b0;
    if4.a = ~a; if4.b = a ^ b; if4.bi = ~bi;
    n = 0; nb = 0;
    while (n < 20) begin
      @(negedge clk);
      if (if4.done) break;
      if (if4.busy) nb++;
      n++;
    end
    chk("timeout4", 32'(n < 20), 32'd1);
    chk("busy_len4", 32'(nb), 32'd4);
    @(posedge clk); #1;
    if4.start = 1'b0;
    chk("done_width4", 32'({if4.busy, if4.done}), 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [8:0] exp);
    int n;
    int nb;
    if8.a = a; if8.b = b; if8.bi = bi; if8.start = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = b; if8.b = a; if8.bi = ~bi;
    n = 0; nb = 0;
    while (n < 30) begin
      @(negedge clk);
      if (if8.done) break;
      if (if8.busy) nb++;
      n++;
    end
    chk("timeout8", 32'(n < 30), 32'd1);
    chk("busy_len8", 32'(nb), 32'd8);
    @(posedge clk); #1;
    chk("done_width8", 32'({if8.busy, if8.done}), 32'd0);
  endtask

  initial begin
    int prev;
    int n;
    logic [3:0] va[3];
    logic [3:0] vb[3];
    logic       vi[3];
    logic [4:0] ve[3];
    logic [7:0] ra, rb;
    logic       ri;

    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bi = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset4", 32'({if4.busy, if4.done, if4.bo, if4.d}), 32'd0);
    chk("reset8", 32'({if8.busy, if8.done, if8.bo, if8.d}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run4(4'd9, 4'd3, 1'b0, 5'h06, 1'b0);
    run4(4'd3, 4'd9, 1'b0, 5'h1A, 1'b0);
    run4(4'd0, 4'd0, 1'b1, 5'h1F, 1'b0);
    run4(4'd15, 4'd15, 1'b0, 5'h00, 1'b0);
    run4(4'd7, 4'd2, 1'b1, 5'h04, 1'b1);

    va = '{4'd12, 4'd2, 4'd14};
    vb = '{4'd5, 4'd6, 4'd1};
    vi = '{1'b0, 1'b1, 1'b1};
    ve = '{5'h07, 5'h1B, 5'h0C};
    if4.start = 1'b1;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      if4.a = va[i]; if4.b = vb[i]; if4.bi = vi[i];
      q4.push_back(ve[i]);
      @(posedge clk); #1;
      if4.a = 4'hF; if4.b = 4'h0; if4.bi = 1'b1;
      n = 0;
      while (n < 20) begin
        @(negedge clk);
        if (if4.done) break;
        n++;
      end
      chk("timeout_b2b", 32'(n < 20), 32'd1);
      if (prev >= 0) chk("b2b_period", 32'(cyc - prev), 32'd6);
      prev = cyc;
      @(posedge clk); #1;
    end
    if4.start = 1'b0;
    @(posedge clk); #1;

    if4.a = 4'd9; if4.b = 4'd3; if4.bi = 1'b0; if4.start = 1'b1;
    q4.push_back(5'h06);
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(if4.busy), 32'd0);
    chk("abort_done", 32'(if4.done), 32'd0);
    chk("abort_d", 32'(if4.d), 32'd0);
    chk("abort_bo", 32'(if4.bo), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    run4(4'd5, 4'd10, 1'b0, 5'h1B, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run4(4'(a), 4'(b), 1'(bi), m4(4'(a), 4'(b), 1'(bi)), 1'b0);

    run8(8'd200, 8'd55, 1'b1, 9'h090);
    run8(8'd0, 8'd0, 1'b1, 9'h1FF);
    run8(8'd255, 8'd255, 1'b0, 9'h000);
    run8(8'd0, 8'd255, 1'b0, 9'h101);
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ri = 1'($urandom_range(0, 1));
      run8(ra, rb, ri, m8(ra, rb, ri));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue4_empty", 32'(q4.size()), 32'd0);
    chk("queue8_empty", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
